// File: rtl/load_store_unit_if.sv
// Bus-side bundle between the load/store unit and the data cache/memory.
// master drives bus_req/we/addr/wdata/wstrb; slave drives bus_ready/rvalid/rdata.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic [3:0]            bus_wstrb;
    logic                  bus_ready;
    logic                  bus_rvalid;
    logic [31:0]           bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one op at a time, lane-positioned stores,
// extended loads, optional split of word-crossing accesses, wait timeout.
// Ports: clk/rst, pipeline side (valid_in, flush, instr_id, rs2_value,
// mem_addr, busy, done, load_data, misalign_exc, bus_timeout), bus (master).
module load_store_unit #(
    parameter int          ADDR_WIDTH           = 32,
    parameter bit          MISALIGN_SPLIT       = 1'b1,
    parameter int unsigned MAX_OUTSTANDING_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic [5:0]            instr_id,
    input  logic [31:0]           rs2_value,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  misalign_exc,
    output logic                  bus_timeout,
    load_store_unit_if.master     bus
);
    localparam logic [5:0] INSTR_LB  = 6'd1;
    localparam logic [5:0] INSTR_LH  = 6'd2;
    localparam logic [5:0] INSTR_LW  = 6'd3;
    localparam logic [5:0] INSTR_LBU = 6'd4;
    localparam logic [5:0] INSTR_LHU = 6'd5;
    localparam logic [5:0] INSTR_SB  = 6'd6;
    localparam logic [5:0] INSTR_SH  = 6'd7;
    localparam logic [5:0] INSTR_SW  = 6'd8;
    localparam logic [15:0] MAXW = 16'(MAX_OUTSTANDING_WAIT);

    typedef enum logic [2:0] {
        IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d, wdata1_q, wdata1_d;
    logic [3:0]            wstrb_q, wstrb_d, wstrb1_q, wstrb1_d;
    logic                  we_q, we_d, split_q, split_d, sext_q, sext_d;
    logic [1:0]            off_q, off_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           part0_q, part0_d, load_data_q, load_data_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  misalign_q, misalign_d, timeout_q, timeout_d;

    logic        dec_mem, dec_load, dec_sext;
    logic [3:0]  dec_mask;
    logic [7:0]  strb_span;
    logic [63:0] data_span;
    logic        crosses, capture, tick;
    logic [31:0] rd_lo, rd_hi, rd_word, rd_ext;

    always_comb begin
        dec_mem  = 1'b1;
        dec_load = 1'b1;
        dec_mask = 4'b0001;
        dec_sext = 1'b0;
        case (instr_id)
            INSTR_LB:  dec_sext = 1'b1;
            INSTR_LH:  begin dec_mask = 4'b0011; dec_sext = 1'b1; end
            INSTR_LW:  dec_mask = 4'b1111;
            INSTR_LBU: dec_mask = 4'b0001;
            INSTR_LHU: dec_mask = 4'b0011;
            INSTR_SB:  dec_load = 1'b0;
            INSTR_SH:  begin dec_mask = 4'b0011; dec_load = 1'b0; end
            INSTR_SW:  begin dec_mask = 4'b1111; dec_load = 1'b0; end
            default:   dec_mem = 1'b0;
        endcase
    end

    // Low half of each span is part 0, high half is part 1 of a split access.
    assign strb_span = {4'b0000, dec_mask} << mem_addr[1:0];
    assign data_span = {32'h0, rs2_value} << {mem_addr[1:0], 3'b000};
    assign crosses   = |strb_span[7:4];
    assign capture   = valid_in && dec_mem && !flush;

    // In WAIT1 part 0 is already latched; otherwise the live word is part 0.
    assign rd_lo   = (state_q == WAIT1) ? part0_q : bus.bus_rdata;
    assign rd_hi   = (state_q == WAIT1) ? bus.bus_rdata : 32'h0;
    assign rd_word = 32'({rd_hi, rd_lo} >> {off_q, 3'b000});

    always_comb begin
        unique case (mask_q)
            4'b0001: rd_ext = {{24{sext_q & rd_word[7]}}, rd_word[7:0]};
            4'b0011: rd_ext = {{16{sext_q & rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wdata1_d    = wdata1_q;
        wstrb1_d    = wstrb1_q;
        we_d        = we_q;
        split_d     = split_q;
        off_d       = off_q;
        mask_d      = mask_q;
        sext_d      = sext_q;
        part0_d     = part0_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        tick        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    if (crosses && !MISALIGN_SPLIT) begin
                        misalign_d = 1'b1;
                    end else begin
                        busy     = 1'b1;
                        state_d  = ISSUE0;
                        cnt_d    = '0;
                        addr_d   = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        wdata_d  = data_span[31:0];
                        wdata1_d = data_span[63:32];
                        wstrb_d  = dec_load ? 4'b0000 : strb_span[3:0];
                        wstrb1_d = dec_load ? 4'b0000 : strb_span[7:4];
                        we_d     = !dec_load;
                        split_d  = crosses;
                        off_d    = mem_addr[1:0];
                        mask_d   = dec_mask;
                        sext_d   = dec_sext;
                    end
                end
            end
            ISSUE0, ISSUE1: begin
                busy = 1'b1;
                if (bus.bus_ready) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        state_d = (state_q == ISSUE0) ? WAIT0 : WAIT1;
                    end else if (state_q == ISSUE0 && split_q) begin
                        state_d = ISSUE1;
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        wdata_d = wdata1_q;
                        wstrb_d = wstrb1_q;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    tick = 1'b1;
                end
            end
            WAIT0, WAIT1: begin
                busy = 1'b1;
                if (bus.bus_rvalid) begin
                    cnt_d = '0;
                    if (state_q == WAIT0 && split_q) begin
                        part0_d = bus.bus_rdata;
                        state_d = ISSUE1;
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                    end else begin
                        load_data_d = rd_ext;
                        state_d     = FINISH;
                    end
                end else begin
                    tick = 1'b1;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tick) begin
            if (MAXW != 16'd0 && cnt_q + 16'd1 == MAXW) begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wdata1_q    <= '0;
            wstrb1_q    <= '0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            off_q       <= '0;
            mask_q      <= '0;
            sext_q      <= 1'b0;
            part0_q     <= '0;
            load_data_q <= '0;
            cnt_q       <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wdata1_q    <= wdata1_d;
            wstrb1_q    <= wstrb1_d;
            we_q        <= we_d;
            split_q     <= split_d;
            off_q       <= off_d;
            mask_q      <= mask_d;
            sext_q      <= sext_d;
            part0_q     <= part0_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.bus_req   = (state_q == ISSUE0) || (state_q == ISSUE1);
    assign bus.bus_we    = we_q & bus.bus_req;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;
    assign load_data     = load_data_q;
    assign misalign_exc  = misalign_q;
    assign bus_timeout   = timeout_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: split and no-split instances,
// bus/load scoreboards, timeout and mid-transaction reset.
module tb_load_store_unit;
    localparam logic [5:0] INSTR_LB  = 6'd1;
    localparam logic [5:0] INSTR_LH  = 6'd2;
    localparam logic [5:0] INSTR_LW  = 6'd3;
    localparam logic [5:0] INSTR_LBU = 6'd4;
    localparam logic [5:0] INSTR_LHU = 6'd5;
    localparam logic [5:0] INSTR_SB  = 6'd6;
    localparam logic [5:0] INSTR_SH  = 6'd7;
    localparam logic [5:0] INSTR_SW  = 6'd8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        ld;
        logic [31:0] data;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid_in, flush;
    logic [5:0]  instr_id;
    logic [31:0] rs2_value, mem_addr;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        busy_s, done_s, mis_s, to_s;
    logic [31:0] ld_s;
    logic        busy_n, done_n, mis_n, to_n;
    logic [31:0] ld_n;

    int tests = 0;
    int fails = 0;
    int unexp_bus = 0;
    int unexp_done = 0;
    int rd_lat = 0;
    int n_mis = 0;
    int n_req = 0;
    int n_done = 0;
    int cyc, m0, r0, d0;
    bus_t  exp_bus[$];
    done_t exp_done[$];
    bus_t  eb;
    done_t ed;
    logic [31:0] ra;
    logic [31:0] mem [logic [31:0]];

    load_store_unit_if #(.ADDR_WIDTH(32)) bs ();
    load_store_unit_if #(.ADDR_WIDTH(32)) bn ();

    assign bs.bus_ready  = ready;
    assign bs.bus_rvalid = rvalid;
    assign bs.bus_rdata  = rdata;
    assign bn.bus_ready  = ready;
    assign bn.bus_rvalid = rvalid;
    assign bn.bus_rdata  = rdata;

    load_store_unit #(
        .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1), .MAX_OUTSTANDING_WAIT(4)
    ) dut_s (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .instr_id(instr_id), .rs2_value(rs2_value), .mem_addr(mem_addr),
        .busy(busy_s), .done(done_s), .load_data(ld_s),
        .misalign_exc(mis_s), .bus_timeout(to_s), .bus(bs)
    );

    load_store_unit #(
        .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b0), .MAX_OUTSTANDING_WAIT(4)
    ) dut_n (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .instr_id(instr_id), .rs2_value(rs2_value), .mem_addr(mem_addr),
        .busy(busy_n), .done(done_n), .load_data(ld_n),
        .misalign_exc(mis_n), .bus_timeout(to_n), .bus(bn)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        bus_t t;
        t.we = 1'b1; t.addr = a; t.strb = s; t.wdata = d;
        exp_bus.push_back(t);
    endtask

    task automatic exp_ld(input logic [31:0] a);
        bus_t t;
        t.we = 1'b0; t.addr = a; t.strb = 4'b0000; t.wdata = 32'h0;
        exp_bus.push_back(t);
    endtask

    task automatic issue(input logic [5:0] id, input logic [31:0] a,
                         input logic [31:0] d);
        valid_in = 1'b1; instr_id = id; mem_addr = a; rs2_value = d;
        #1;
        check("busy_capture", 64'(busy_s), 64'd1);
        @(negedge clk);
        valid_in = 1'b0; instr_id = 6'd0;
    endtask

    task automatic wait_done(input string tag, output int c);
        c = 1;
        while (!done_s && c < 40) begin
            check({tag, "_busy"}, 64'(busy_s), 64'd1);
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, 64'(done_s), 64'd1);
        check({tag, "_busy_fin"}, 64'(busy_s), 64'd0);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [5:0] id,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic ld, input logic [31:0] ldv,
                       output int c);
        done_t t;
        t.ld = ld; t.data = ldv;
        exp_done.push_back(t);
        issue(id, a, d);
        wait_done(tag, c);
    endtask

    always @(negedge clk) begin
        if (!rst && bs.bus_req && bs.bus_ready) begin
            if (exp_bus.size() == 0) begin
                unexp_bus++;
            end else begin
                eb = exp_bus.pop_front();
                check("bus_we", 64'(bs.bus_we), 64'(eb.we));
                check("bus_addr", 64'(bs.bus_addr), 64'(eb.addr));
                check("bus_wstrb", 64'(bs.bus_wstrb), 64'(eb.strb));
                if (eb.we) check("bus_wdata", 64'(bs.bus_wdata), 64'(eb.wdata));
            end
        end
    end

    always @(negedge clk) begin
        if (done_s) begin
            if (exp_done.size() == 0) begin
                unexp_done++;
            end else begin
                ed = exp_done.pop_front();
                if (ed.ld) check("load_data", 64'(ld_s), 64'(ed.data));
            end
        end
        if (mis_n) n_mis++;
        if (bn.bus_req) n_req++;
        if (done_n) n_done++;
    end

    always begin
        @(negedge clk);
        if (!rst && bs.bus_req && bs.bus_ready && !bs.bus_we) begin
            ra = bs.bus_addr;
            @(posedge clk);
            repeat (rd_lat) @(posedge clk);
            #1;
            rvalid = 1'b1;
            rdata  = mem.exists(ra) ? mem[ra] : 32'h0;
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            rdata  = 32'h0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; instr_id = 6'd0;
        rs2_value = 32'h0; mem_addr = 32'h0;
        ready = 1'b1; rvalid = 1'b0; rdata = 32'h0;
        mem[32'h100] = 32'h1234_5678;
        mem[32'h300] = 32'h8001_80FF;
        mem[32'h400] = 32'hAABB_CCDD;
        mem[32'h404] = 32'h1122_3344;
        repeat (3) @(negedge clk);

        check("reset_s_ctl", 64'({busy_s, done_s, mis_s, to_s,
              bs.bus_req, bs.bus_we, bs.bus_wstrb}), 64'd0);
        check("reset_s_bus", {bs.bus_addr, bs.bus_wdata}, 64'd0);
        check("reset_s_ldata", 64'(ld_s), 64'd0);
        check("reset_n_ctl", 64'({busy_n, done_n, mis_n, to_n,
              bn.bus_req, bn.bus_we, bn.bus_wstrb}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        exp_st(32'h100, 4'b1111, 32'hDEAD_BEEF);
        run("sw_aligned", INSTR_SW, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0, cyc);
        check("sw_latency", 64'(cyc), 64'd2);

        exp_st(32'h200, 4'b1000, 32'hAB00_0000);
        run("sb_off3", INSTR_SB, 32'h203, 32'h0000_00AB, 1'b0, 32'h0, cyc);
        exp_st(32'h200, 4'b1100, 32'h1234_0000);
        run("sh_off2", INSTR_SH, 32'h202, 32'h0000_1234, 1'b0, 32'h0, cyc);
        exp_st(32'h204, 4'b0010, 32'h0000_5500);
        run("sb_off1", INSTR_SB, 32'h205, 32'h0000_0055, 1'b0, 32'h0, cyc);

        rd_lat = 3;
        exp_ld(32'h300);
        run("lb_late", INSTR_LB, 32'h301, 32'h0, 1'b1, 32'hFFFF_FF80, cyc);
        check("lb_latency", 64'(cyc), 64'd6);
        exp_ld(32'h300);
        run("lbu_late", INSTR_LBU, 32'h301, 32'h0, 1'b1, 32'h0000_0080, cyc);
        rd_lat = 0;

        exp_ld(32'h300);
        run("lh_sext", INSTR_LH, 32'h302, 32'h0, 1'b1, 32'hFFFF_8001, cyc);
        exp_ld(32'h300);
        run("lhu_off1", INSTR_LHU, 32'h301, 32'h0, 1'b1, 32'h0000_0180, cyc);
        exp_ld(32'h300);
        run("lb_off3", INSTR_LB, 32'h303, 32'h0, 1'b1, 32'hFFFF_FF80, cyc);
        exp_ld(32'h100);
        run("lw_aligned", INSTR_LW, 32'h100, 32'h0, 1'b1, 32'h1234_5678, cyc);

        m0 = n_mis; r0 = n_req; d0 = n_done;
        exp_ld(32'h400);
        exp_ld(32'h404);
        run("lw_split", INSTR_LW, 32'h402, 32'h0, 1'b1, 32'h3344_AABB, cyc);
        exp_st(32'h400, 4'b1100, 32'h7788_0000);
        exp_st(32'h404, 4'b0011, 32'h0000_5566);
        run("sw_split", INSTR_SW, 32'h402, 32'h5566_7788, 1'b0, 32'h0, cyc);
        exp_st(32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        exp_st(32'h0000_0000, 4'b0111, 32'h00DE_ADBE);
        run("sw_wrap", INSTR_SW, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 32'h0, cyc);
        check("nosplit_misalign_cnt", 64'(n_mis - m0), 64'd3);
        check("nosplit_req_cnt", 64'(n_req - r0), 64'd0);
        check("nosplit_done_cnt", 64'(n_done - d0), 64'd0);

        valid_in = 1'b1; flush = 1'b1; instr_id = INSTR_SW;
        mem_addr = 32'h600; rs2_value = 32'h1;
        #1;
        check("flush_busy", 64'(busy_s), 64'd0);
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("flush_idle", 64'({busy_s, bs.bus_req, done_s}), 64'd0);

        valid_in = 1'b1; instr_id = 6'd20;
        #1;
        check("nonmem_busy", 64'(busy_s), 64'd0);
        @(negedge clk);
        valid_in = 1'b0; instr_id = 6'd0;
        repeat (2) @(negedge clk);
        check("nonmem_idle", 64'({busy_s, bs.bus_req}), 64'd0);

        ready = 1'b0;
        issue(INSTR_SW, 32'h500, 32'h1);
        cyc = 1;
        while (!to_s && cyc < 20) begin
            check("timeout_req_held", 64'(bs.bus_req), 64'd1);
            @(negedge clk);
            cyc++;
        end
        check("timeout_pulse", 64'(to_s), 64'd1);
        check("timeout_idle", 64'({busy_s, bs.bus_req, done_s}), 64'd0);
        @(negedge clk);
        check("timeout_one_cycle", 64'(to_s), 64'd0);
        ready = 1'b1;
        @(negedge clk);

        rd_lat = 10;
        exp_ld(32'h100);
        issue(INSTR_LW, 32'h100, 32'h0);
        @(negedge clk);
        check("wait0_busy", 64'(busy_s), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctl", 64'({busy_s, done_s, mis_s, to_s,
              bs.bus_req, bs.bus_we, bs.bus_wstrb}), 64'd0);
        check("rst_mid_bus", {bs.bus_addr, bs.bus_wdata}, 64'd0);
        check("rst_mid_ldata", 64'(ld_s), 64'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_mid_idle", 64'({busy_s, bs.bus_req}), 64'd0);
        rd_lat = 0;

        exp_st(32'h100, 4'b1111, 32'hCAFE_F00D);
        run("sw_after_rst", INSTR_SW, 32'h100, 32'hCAFE_F00D, 1'b0, 32'h0, cyc);

        repeat (3) @(negedge clk);
        check("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done.size()), 64'd0);
        check("unexpected_bus", 64'(unexp_bus), 64'd0);
        check("unexpected_done", 64'(unexp_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
